// File: rtl/mem_arbiter_rr.sv
// Round-robin arbiter that puts NUM_PORTS cache-line clients onto one pmem port.
// Latency: 1 cycle from IDLE to grant. Back-to-back grants chain on pmem_resp with no idle cycle.
// Backpressure: a client holds its request until its resp; ports that are not granted wait.
//
// Ports: clk/rst (async, active-high); req_read/req_write/req_addr/req_wdata per client;
//   req_resp/req_rdata back to each client; pmem_read/pmem_write/pmem_addr/pmem_wdata
//   to memory; pmem_resp/pmem_rdata from memory; arb_timeout sticky watchdog flag.
// Optional: define ARB_TIMEOUT_EN to add the BUSY watchdog and the arb_timeout port.
module mem_arbiter_rr #(
  parameter int NUM_PORTS      = 2,
  parameter int DATA_W         = 256,
  parameter int ADDR_W         = 32,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NUM_PORTS-1:0]        req_read,
  input  logic [NUM_PORTS-1:0]        req_write,
  input  logic [NUM_PORTS*ADDR_W-1:0] req_addr,
  input  logic [NUM_PORTS*DATA_W-1:0] req_wdata,
  output logic [NUM_PORTS-1:0]        req_resp,
  output logic [NUM_PORTS*DATA_W-1:0] req_rdata,
  output logic                        pmem_read,
  output logic                        pmem_write,
  output logic [ADDR_W-1:0]           pmem_addr,
  output logic [DATA_W-1:0]           pmem_wdata,
  input  logic                        pmem_resp,
  input  logic [DATA_W-1:0]           pmem_rdata
`ifdef ARB_TIMEOUT_EN
  ,
  output logic                        arb_timeout
`endif
);

  localparam int IW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

  if (NUM_PORTS < 2) begin : g_bad_ports
    $error("mem_arbiter_rr needs at least two ports");
  end
  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("mem_arbiter_rr needs TIMEOUT_CYCLES >= 1");
  end

  typedef enum logic {IDLE, BUSY} state_t;

  state_t               state;
  logic [IW-1:0]        grant;
  logic [IW-1:0]        rr_ptr;
  logic [NUM_PORTS-1:0] req;
  logic                 timeout_hit;

  assign req = req_read | req_write;

  // Two searches run in parallel: from rr_ptr+1 over all ports (used in IDLE) and
  // from grant+1 over the other NUM_PORTS-1 ports (used for chaining on pmem_resp).
  // Indices carry one extra bit so the wrap works for non-power-of-two port counts.
  logic [IW-1:0] idle_pick, chain_pick;
  logic          idle_hit, chain_hit;
  logic [IW:0]   ia, ic;

  always_comb begin
    idle_pick  = '0;
    idle_hit   = 1'b0;
    chain_pick = '0;
    chain_hit  = 1'b0;
    ia         = '0;
    ic         = '0;
    for (int k = 1; k <= NUM_PORTS; k++) begin
      ia = {1'b0, rr_ptr} + (IW+1)'(k);
      if (ia >= (IW+1)'(NUM_PORTS)) ia = ia - (IW+1)'(NUM_PORTS);
      if (!idle_hit && req[ia[IW-1:0]]) begin
        idle_hit  = 1'b1;
        idle_pick = ia[IW-1:0];
      end
      if (k < NUM_PORTS) begin
        ic = {1'b0, grant} + (IW+1)'(k);
        if (ic >= (IW+1)'(NUM_PORTS)) ic = ic - (IW+1)'(NUM_PORTS);
        if (!chain_hit && req[ic[IW-1:0]]) begin
          chain_hit  = 1'b1;
          chain_pick = ic[IW-1:0];
        end
      end
    end
  end

  // Memory side and responses follow the granted port combinationally while BUSY;
  // gating with rst keeps everything quiet for the whole reset window.
  always_comb begin
    pmem_read  = 1'b0;
    pmem_write = 1'b0;
    pmem_addr  = '0;
    pmem_wdata = '0;
    req_resp   = '0;
    req_rdata  = '0;
    if (state == BUSY && !rst) begin
      pmem_read  = req_read[grant];
      pmem_write = req_write[grant];
      pmem_addr  = req_addr[int'(grant)*ADDR_W +: ADDR_W];
      pmem_wdata = req_wdata[int'(grant)*DATA_W +: DATA_W];
      req_resp[grant] = pmem_resp;
      req_rdata[int'(grant)*DATA_W +: DATA_W] = pmem_rdata;
    end
  end

`ifdef ARB_TIMEOUT_EN
  localparam int TCW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TCW-1:0] to_cnt;

  // Fires on the TIMEOUT_CYCLES-th consecutive BUSY cycle without a response.
  assign timeout_hit = (state == BUSY) && !pmem_resp && req[grant] &&
                       (to_cnt == TCW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      to_cnt      <= '0;
      arb_timeout <= 1'b0;
    end else begin
      if (state == BUSY && !pmem_resp && req[grant] && !timeout_hit)
        to_cnt <= to_cnt + 1'b1;
      else
        to_cnt <= '0;
      if (timeout_hit) arb_timeout <= 1'b1;
    end
  end
`else
  assign timeout_hit = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      grant  <= '0;
      rr_ptr <= IW'(NUM_PORTS - 1);
    end else begin
      case (state)
        IDLE: begin
          if (idle_hit) begin
            grant <= idle_pick;
            state <= BUSY;
          end
        end
        BUSY: begin
          if (pmem_resp) begin
            rr_ptr <= grant;
            if (chain_hit) grant <= chain_pick;
            else           state <= IDLE;
          end else if (!req[grant]) begin
            // Abort: pointer untouched so the aborting port keeps its place.
            state <= IDLE;
          end else if (timeout_hit) begin
            // Hung transaction: skip past it so the others get served.
            rr_ptr <= grant;
            state  <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter_rr.sv
module tb_mem_arbiter_rr;

  localparam int NP = 3;
  localparam int DW = 32;
  localparam int AW = 16;
  localparam int TO = 8;

  logic              clk;
  logic              rst;
  logic [NP-1:0]     req_read;
  logic [NP-1:0]     req_write;
  logic [NP*AW-1:0]  req_addr;
  logic [NP*DW-1:0]  req_wdata;
  logic [NP-1:0]     req_resp;
  logic [NP*DW-1:0]  req_rdata;
  logic              pmem_read;
  logic              pmem_write;
  logic [AW-1:0]     pmem_addr;
  logic [DW-1:0]     pmem_wdata;
  logic              pmem_resp;
  logic [DW-1:0]     pmem_rdata;
`ifdef ARB_TIMEOUT_EN
  logic              arb_timeout;
`endif

  mem_arbiter_rr #(
    .NUM_PORTS(NP), .DATA_W(DW), .ADDR_W(AW), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .rst(rst),
    .req_read(req_read), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .req_resp(req_resp), .req_rdata(req_rdata),
    .pmem_read(pmem_read), .pmem_write(pmem_write),
    .pmem_addr(pmem_addr), .pmem_wdata(pmem_wdata),
    .pmem_resp(pmem_resp), .pmem_rdata(pmem_rdata)
`ifdef ARB_TIMEOUT_EN
    , .arb_timeout(arb_timeout)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: which port owns the memory (-1 = nobody), who was served last,
  // how long the current owner has been waiting, and the sticky watchdog flag.
  int            owner;
  int            last;
  int            wait_cnt;
  bit            to_flag;
  logic [NP-1:0] last_resp;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic bit wants(input int p);
    return (req_read[p] | req_write[p]) == 1'b1;
  endfunction

  // Nearest requester after 'base' in circular order, skipping 'excl'.
  function automatic int rr_pick(input int base, input int excl);
    int best = -1;
    int bestd = NP;
    int d;
    for (int p = 0; p < NP; p++) begin
      if (wants(p) && p != excl) begin
        d = (p - base - 1 + 2 * NP) % NP;
        if (d < bestd) begin
          bestd = d;
          best  = p;
        end
      end
    end
    return best;
  endfunction

  task automatic set_port(input int p, input logic rd, input logic wr,
                          input logic [AW-1:0] a, input logic [DW-1:0] d);
    req_read[p]  = rd;
    req_write[p] = wr;
    req_addr[p*AW +: AW]  = a;
    req_wdata[p*DW +: DW] = d;
  endtask

  task automatic clear_all();
    req_read  = '0;
    req_write = '0;
    pmem_resp = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    chk("rst_read", 128'(pmem_read), 128'(0));
    chk("rst_write", 128'(pmem_write), 128'(0));
    chk("rst_addr", 128'(pmem_addr), 128'(0));
    chk("rst_wdata", 128'(pmem_wdata), 128'(0));
    chk("rst_resp", 128'(req_resp), 128'(0));
    chk("rst_rdata", 128'(req_rdata), 128'(0));
`ifdef ARB_TIMEOUT_EN
    chk("rst_timeout", 128'(arb_timeout), 128'(0));
`endif
    owner     = -1;
    last      = NP - 1;
    wait_cnt  = 0;
    to_flag   = 1'b0;
    last_resp = '0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Called at a negedge with the cycle's inputs applied: check outputs against the
  // model, advance the model across the coming posedge, return at the next negedge.
  task automatic step();
    logic [NP-1:0]    e_resp;
    logic [NP*DW-1:0] e_rdata;
    logic             e_rd, e_wr;
    logic [AW-1:0]    e_addr;
    logic [DW-1:0]    e_wd;
    #1;
    e_resp = '0; e_rdata = '0; e_rd = 1'b0; e_wr = 1'b0; e_addr = '0; e_wd = '0;
    if (owner >= 0) begin
      e_rd   = req_read[owner];
      e_wr   = req_write[owner];
      e_addr = req_addr[owner*AW +: AW];
      e_wd   = req_wdata[owner*DW +: DW];
      e_resp[owner] = pmem_resp;
      e_rdata[owner*DW +: DW] = pmem_rdata;
    end
    for (int p = 0; p < NP; p++)
      if (req_read[p] && req_write[p])
        $display("note: port %0d asserts read and write together (protocol violation)", p);
    chk("pmem_read", 128'(pmem_read), 128'(e_rd));
    chk("pmem_write", 128'(pmem_write), 128'(e_wr));
    chk("pmem_addr", 128'(pmem_addr), 128'(e_addr));
    chk("pmem_wdata", 128'(pmem_wdata), 128'(e_wd));
    chk("req_resp", 128'(req_resp), 128'(e_resp));
    chk("req_rdata", 128'(req_rdata), 128'(e_rdata));
`ifdef ARB_TIMEOUT_EN
    chk("arb_timeout", 128'(arb_timeout), 128'(to_flag));
`endif
    last_resp = e_resp;
    if (owner < 0) begin
      owner = rr_pick(last, -1);
      wait_cnt = 0;
    end else if (pmem_resp) begin
      last     = owner;
      owner    = rr_pick(last, last);
      wait_cnt = 0;
    end else if (!wants(owner)) begin
      owner    = -1;
      wait_cnt = 0;
    end else begin
`ifdef ARB_TIMEOUT_EN
      wait_cnt++;
      if (wait_cnt >= TO) begin
        to_flag  = 1'b1;
        last     = owner;
        owner    = -1;
        wait_cnt = 0;
      end
`endif
    end
    @(negedge clk);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    int idle_cnt;
    rst = 1'b1;
    req_read = '0; req_write = '0; req_addr = '0; req_wdata = '0;
    pmem_resp = 1'b0; pmem_rdata = '0;
    repeat (2) @(negedge clk);

    // Single read from port 0.
    do_reset();
    set_port(0, 1'b1, 1'b0, 16'h0100, 32'h0);
    step();
    #1;
    chk("t1_read", 128'(pmem_read), 128'(1));
    chk("t1_addr", 128'(pmem_addr), 128'(16'h0100));
    step();
    pmem_resp = 1'b1; pmem_rdata = 32'hAAAAAAAA;
    #1;
    chk("t1_resp", 128'(req_resp), 128'(3'b001));
    chk("t1_rdata", 128'(req_rdata), 128'({32'h0, 32'h0, 32'hAAAAAAAA}));
    step();
    clear_all();
    step();

    // All ports requesting, resp every 4th cycle: 0,1,2,0,1,2 with no gaps.
    do_reset();
    for (int p = 0; p < NP; p++) set_port(p, 1'b1, 1'b0, AW'(16 + p), DW'(p));
    step();
    idle_cnt = 0;
    for (int g = 0; g < 6; g++) begin
      for (int c = 0; c < 4; c++) begin
        pmem_resp = (c == 3);
        pmem_rdata = DW'($urandom);
        #1;
        if (!pmem_read) idle_cnt++;
        if (c == 3) chk("t2_order", 128'(pmem_addr), 128'(16 + (g % 3)));
        step();
      end
    end
    pmem_resp = 1'b0;
    chk("t2_no_idle", 128'(idle_cnt), 128'(0));
    clear_all();
    step();
    step();

    // Port 1 write while port 0 idle.
    do_reset();
    set_port(1, 1'b0, 1'b1, 16'h0200, 32'h55555555);
    step();
    #1;
    chk("t3_write", 128'(pmem_write), 128'(1));
    chk("t3_read", 128'(pmem_read), 128'(0));
    chk("t3_wdata", 128'(pmem_wdata), 128'(32'h55555555));
    step();
    pmem_resp = 1'b1;
    #1;
    chk("t3_resp", 128'(req_resp), 128'(3'b010));
    step();
    clear_all();
    step();

    // Abort: port 0 drops before resp; pointer stays so port 0 wins again.
    do_reset();
    set_port(0, 1'b1, 1'b0, 16'h0300, 32'h0);
    step();
    step();
    req_read[0] = 1'b0;
    #1;
    chk("t4_drop", 128'(pmem_read), 128'(0));
    step();
    set_port(0, 1'b1, 1'b0, 16'h0300, 32'h0);
    set_port(1, 1'b1, 1'b0, 16'h0310, 32'h0);
    step();
    #1;
    chk("t4_next", 128'(pmem_addr), 128'(16'h0300));
    pmem_resp = 1'b1;
    step();
    clear_all();
    step();
    step();

    // Reset in the middle of a BUSY transfer with a response on the bus.
    do_reset();
    set_port(2, 1'b1, 1'b0, 16'h0400, 32'h0);
    step();
    pmem_resp = 1'b1; pmem_rdata = 32'h12345678;
    set_port(0, 1'b1, 1'b0, 16'h0410, 32'h0);
    #1;
    chk("t5_busy", 128'(pmem_read), 128'(1));
    do_reset();
    pmem_resp = 1'b0;
    step();
    #1;
    chk("t5_first", 128'(pmem_addr), 128'(16'h0410));
    clear_all();
    step();
    step();

    // Read and write together are forwarded as-is.
    do_reset();
    set_port(1, 1'b1, 1'b1, 16'h0500, 32'hCAFEF00D);
    step();
    #1;
    chk("t6_rd", 128'(pmem_read), 128'(1));
    chk("t6_wr", 128'(pmem_write), 128'(1));
    pmem_resp = 1'b1;
    step();
    clear_all();
    step();

`ifdef ARB_TIMEOUT_EN
    // Memory never answers: watchdog after TO BUSY cycles, then port 1 gets served.
    do_reset();
    set_port(0, 1'b1, 1'b0, 16'h0600, 32'h0);
    set_port(1, 1'b1, 1'b0, 16'h0610, 32'h0);
    step();
    for (int c = 0; c < TO - 1; c++) step();
    #1;
    chk("t7_not_yet", 128'(arb_timeout), 128'(0));
    step();
    #1;
    chk("t7_flag", 128'(arb_timeout), 128'(1));
    step();
    #1;
    chk("t7_next", 128'(pmem_addr), 128'(16'h0610));
    clear_all();
    step();
`endif

    // Random traffic against the model.
    do_reset();
    for (int t = 0; t < 2000; t++) begin
      if (t == 1000) do_reset();
      for (int p = 0; p < NP; p++) begin
        if (last_resp[p]) begin
          req_read[p] = 1'b0; req_write[p] = 1'b0;
        end else if (!wants(p)) begin
          if ($urandom_range(0, 2) == 0) begin
            logic w;
            w = 1'($urandom_range(0, 1));
            set_port(p, !w, w, AW'($urandom), DW'($urandom));
          end
        end else if ($urandom_range(0, 39) == 0) begin
          req_read[p] = 1'b0; req_write[p] = 1'b0;
        end
      end
      pmem_resp  = ($urandom_range(0, 3) == 0);
      pmem_rdata = DW'($urandom);
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
